// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline control block.
//   state_e   : control FSM state (normal flow / redirect waiting on a fetch)
//   reg_idx_t : 3-bit architectural register index
//   addr_t    : 16-bit instruction address
package pipeline_control_pkg;

    typedef enum logic [0:0] {
        StRun       = 1'b0,
        StRedirPend = 1'b1
    } state_e;

    typedef logic [2:0]  reg_idx_t;
    typedef logic [15:0] addr_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : rising-edge clock
//   clr_i   : synchronous clear to zero (wins over inc_i)
//   inc_i   : add one this cycle unless already all-ones
//   count_o : current count
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Five-stage pipeline hazard / redirect controller.
//   clk, reset                 : clock, synchronous active-high reset
//   imem_req/imem_resp         : fetch outstanding / fetch completes
//   dmem_req/dmem_resp         : data access outstanding / access completes
//   ex_is_load, ex_dest        : load in ID/EX and its destination
//   id_sr1/2, id_sr1/2_used    : IF/ID sources and whether they are read
//   br_taken, br_target        : taken control transfer resolved in MEM
//   load_*                     : stage-register load enables
//   flush_*                    : stage-register clears (override load)
//   redirect, redirect_target  : PC mux select and address
//   stall_cycles               : saturating count of cycles with load_pc=0
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 ex_is_load,
    input  reg_idx_t             ex_dest,
    input  reg_idx_t             id_sr1,
    input  reg_idx_t             id_sr2,
    input  logic                 id_sr1_used,
    input  logic                 id_sr2_used,
    input  logic                 br_taken,
    input  addr_t                br_target,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic                 redirect,
    output addr_t                redirect_target,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    state_e state_d, state_q;
    addr_t  target_d, target_q;

    logic imem_stall, dmem_stall, load_use;

    assign imem_stall = imem_req & ~imem_resp;
    assign dmem_stall = dmem_req & ~dmem_resp;
    assign load_use   = ex_is_load &
                        ((id_sr1_used & (id_sr1 == ex_dest)) |
                         (id_sr2_used & (id_sr2 == ex_dest)));

    always_comb begin
        load_pc         = 1'b1;
        load_if_id      = 1'b1;
        load_id_ex      = 1'b1;
        load_ex_mem     = 1'b1;
        load_mem_wb     = 1'b1;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_ex_mem    = 1'b0;
        redirect        = 1'b0;
        redirect_target = target_q;
        state_d         = state_q;
        target_d        = target_q;

        if (reset) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (dmem_stall) begin
            // Whole pipe freezes; a branch sitting in MEM is re-seen once the access completes.
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (br_taken) begin
                        // Branch wins over load_use: the dependent instruction is flushed anyway.
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        if (imem_stall) begin
                            // Fetch still busy: park the target until the fetch drains.
                            load_pc    = 1'b0;
                            load_if_id = 1'b0;
                            target_d   = br_target;
                            state_d    = StRedirPend;
                        end else begin
                            redirect        = 1'b1;
                            redirect_target = br_target;
                        end
                    end else if (load_use || imem_stall) begin
                        load_pc     = 1'b0;
                        load_if_id  = 1'b0;
                        flush_id_ex = 1'b1;
                    end
                end
                StRedirPend: begin
                    // Only bubbles reach MEM here, so br_taken is ignored.
                    load_if_id  = 1'b0;
                    flush_if_id = 1'b1;
                    if (imem_resp) begin
                        redirect = 1'b1;
                        state_d  = StRun;
                    end else begin
                        load_pc = 1'b0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    sat_counter #(
        .Width (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .inc_i   (~load_pc),
        .count_o (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_resp, dmem_req, dmem_resp;
    logic        ex_is_load;
    logic [2:0]  ex_dest, id_sr1, id_sr2;
    logic        id_sr1_used, id_sr2_used;
    logic        br_taken;
    logic [15:0] br_target;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, redirect;
    logic [15:0] redirect_target;
    logic [15:0] stall_cycles;

    logic        l4_pc, l4_if_id, l4_id_ex, l4_ex_mem, l4_mem_wb;
    logic        f4_if_id, f4_id_ex, f4_ex_mem, redirect4;
    logic [15:0] redirect_target4;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .br_taken(br_taken), .br_target(br_target),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .redirect(redirect), .redirect_target(redirect_target),
        .stall_cycles(stall_cycles)
    );

    pipeline_control #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .br_taken(br_taken), .br_target(br_target),
        .load_pc(l4_pc), .load_if_id(l4_if_id), .load_id_ex(l4_id_ex),
        .load_ex_mem(l4_ex_mem), .load_mem_wb(l4_mem_wb),
        .flush_if_id(f4_if_id), .flush_id_ex(f4_id_ex), .flush_ex_mem(f4_ex_mem),
        .redirect(redirect4), .redirect_target(redirect_target4),
        .stall_cycles(stall_cycles4)
    );

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    //  flush_if_id, flush_id_ex, flush_ex_mem, redirect}
    logic [8:0] ctl_obs;
    assign ctl_obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                      flush_if_id, flush_id_ex, flush_ex_mem, redirect};

    localparam logic [8:0] CtlRun      = 9'b11111_000_0;
    localparam logic [8:0] CtlRst      = 9'b00000_111_0;
    localparam logic [8:0] CtlBubble   = 9'b00111_010_0;
    localparam logic [8:0] CtlDStall   = 9'b00000_000_0;
    localparam logic [8:0] CtlBr       = 9'b11111_111_1;
    localparam logic [8:0] CtlBrStall  = 9'b00111_111_0;
    localparam logic [8:0] CtlPend     = 9'b00111_100_0;
    localparam logic [8:0] CtlPendResp = 9'b10111_100_1;

    typedef struct {
        string       tag;
        int          kind;   // 0 ctl, 1 target, 2 count, 3 count (4-bit instance)
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic exp_ctl(input string tag, input logic [8:0] v);
        q.push_back('{tag, 0, {7'b0, v}});
    endtask

    task automatic exp_tgt(input string tag, input logic [15:0] v);
        q.push_back('{tag, 1, v});
    endtask

    task automatic exp_cnt(input string tag, input logic [15:0] v);
        q.push_back('{tag, 2, v});
    endtask

    task automatic exp_cnt4(input string tag, input logic [3:0] v);
        q.push_back('{tag, 3, {12'b0, v}});
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       obs = {7'b0, ctl_obs};
                1:       obs = redirect_target;
                2:       obs = stall_cycles;
                default: obs = {12'b0, stall_cycles4};
            endcase
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs are driven 1 time unit after posedge; comparisons happen at the following negedge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0;
        dmem_req = 1'b0; dmem_resp = 1'b0;
        ex_is_load = 1'b0; ex_dest = 3'd0;
        id_sr1 = 3'd0; id_sr2 = 3'd0;
        id_sr1_used = 1'b0; id_sr2_used = 1'b0;
        br_taken = 1'b0; br_target = 16'h0000;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        exp_ctl("reset_ctl_0", CtlRst);
        cycle();
        exp_ctl("reset_ctl_1", CtlRst);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        #1;

        // Reset then idle
        do_reset();
        exp_ctl("idle_ctl", CtlRun);
        exp_tgt("idle_tgt", 16'h0000);
        exp_cnt("idle_cnt", 16'd0);
        cycle();

        // Load-use on sr1
        ex_is_load = 1'b1; ex_dest = 3'd3; id_sr1 = 3'd3; id_sr1_used = 1'b1;
        exp_ctl("lu_sr1_ctl", CtlBubble);
        cycle();
        idle();
        exp_ctl("lu_after_ctl", CtlRun);
        exp_cnt("lu_after_cnt", 16'd1);
        cycle();
        // Matching index but source not read: no hazard
        ex_is_load = 1'b1; ex_dest = 3'd3; id_sr1 = 3'd3; id_sr1_used = 1'b0;
        exp_ctl("lu_unused_ctl", CtlRun);
        cycle();
        // Load-use on sr2
        idle();
        ex_is_load = 1'b1; ex_dest = 3'd5; id_sr2 = 3'd5; id_sr2_used = 1'b1;
        exp_ctl("lu_sr2_ctl", CtlBubble);
        cycle();
        // Not a load: no hazard
        ex_is_load = 1'b0;
        exp_ctl("nonload_ctl", CtlRun);
        exp_cnt("lu_sr2_cnt", 16'd2);
        cycle();

        // dmem stall 4 cycles with branch in cycle 2
        do_reset();
        dmem_req = 1'b1;
        exp_ctl("dm_c1_ctl", CtlDStall);
        cycle();
        br_taken = 1'b1; br_target = 16'h4444;
        exp_ctl("dm_c2_ctl", CtlDStall);
        cycle();
        br_taken = 1'b0;
        exp_ctl("dm_c3_ctl", CtlDStall);
        cycle();
        dmem_resp = 1'b1;
        exp_ctl("dm_c4_ctl", CtlRun);
        cycle();
        idle();
        exp_cnt("dm_cnt", 16'd3);
        exp_tgt("dm_tgt", 16'h0000);
        cycle();

        // Branch without imem stall, concurrent load-use discarded
        br_taken = 1'b1; br_target = 16'h1234;
        ex_is_load = 1'b1; ex_dest = 3'd2; id_sr1 = 3'd2; id_sr1_used = 1'b1;
        exp_ctl("br_ctl", CtlBr);
        exp_tgt("br_tgt", 16'h1234);
        cycle();
        idle();
        exp_ctl("br_after_ctl", CtlRun);
        exp_tgt("br_hold_tgt", 16'h0000);
        exp_cnt("br_cnt", 16'd3);
        cycle();

        // Branch during imem stall -> REDIR_PEND
        do_reset();
        imem_req = 1'b1; br_taken = 1'b1; br_target = 16'h3000;
        exp_ctl("rp_enter_ctl", CtlBrStall);
        cycle();
        br_target = 16'h5555;   // new branch in REDIR_PEND must be ignored
        exp_ctl("rp_w1_ctl", CtlPend);
        exp_tgt("rp_w1_tgt", 16'h3000);
        cycle();
        br_taken = 1'b0;
        exp_ctl("rp_w2_ctl", CtlPend);
        cycle();
        imem_resp = 1'b1;
        exp_ctl("rp_resp_ctl", CtlPendResp);
        exp_tgt("rp_resp_tgt", 16'h3000);
        cycle();
        idle();
        exp_ctl("rp_after_ctl", CtlRun);
        exp_cnt("rp_cnt", 16'd3);
        cycle();

        // Reset during REDIR_PEND
        do_reset();
        imem_req = 1'b1; br_taken = 1'b1; br_target = 16'h7abc;
        exp_ctl("rr_enter_ctl", CtlBrStall);
        cycle();
        br_taken = 1'b0;
        exp_ctl("rr_pend_ctl", CtlPend);
        cycle();
        reset = 1'b1; imem_resp = 1'b1;
        exp_ctl("rr_reset_ctl", CtlRst);
        cycle();
        idle();
        imem_req = 1'b1; imem_resp = 1'b1;
        exp_ctl("rr_after_ctl", CtlRun);
        exp_tgt("rr_after_tgt", 16'h0000);
        exp_cnt("rr_after_cnt", 16'd0);
        cycle();

        // 20 imem stall cycles: 4-bit counter saturates
        do_reset();
        imem_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) exp_ctl("is_ctl", CtlBubble);
            if (i == 15) exp_cnt4("is_c15_cnt4", 4'hE);
            if (i == 16) exp_cnt4("is_c16_cnt4", 4'hF);
            if (i == 17) exp_cnt4("is_c17_cnt4", 4'hF);
            cycle();
        end
        idle();
        exp_cnt4("sat_cnt4", 4'hF);
        exp_cnt("sat_cnt16", 16'd20);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, width of the stall-cycle counter.
REQ-002 The block SHALL have these ports:
 clk  input  1  rising-edge clock.
 reset  input  1  synchronous, active-high reset.
 imem_req  input  1  IF stage has an instruction fetch outstanding.
 imem_resp  input  1  instruction memory completes the fetch this cycle.
 dmem_req  input  1  MEM stage has a data read/write outstanding.
 dmem_resp  input  1  data memory completes the access this cycle.
 ex_is_load  input  1  ID/EX holds a load (LDR/LDB/LDI).
 ex_dest  input  3  ID/EX destination register.
 id_sr1, id_sr2  input  3 each  IF/ID source registers.
 id_sr1_used, id_sr2_used  input  1 each  source actually read.
 br_taken  input  1  MEM stage resolves a taken branch/JMP/TRAP.
 br_target  input  16  redirect address for br_taken.
 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage-register load enables.
 flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  stage-register clears (flush beats load in the register).
 redirect  output  1  PC mux selects redirect_target this cycle.
 redirect_target  output  16  registered branch target.
 stall_cycles  output  CNT_WIDTH  saturating count of cycles with load_pc=0.

Function
REQ-003 imem_stall SHALL be imem_req & ~imem_resp; dmem_stall SHALL be dmem_req & ~dmem_resp.
REQ-004 load_use SHALL be ex_is_load & ((id_sr1_used & id_sr1==ex_dest) | (id_sr2_used & id_sr2==ex_dest)).
REQ-005 The FSM SHALL have states RUN and REDIR_PEND.
REQ-006 In any state, dmem_stall SHALL hold every load_* and flush_* output at 0 and suppress br_taken handling; priority order is dmem_stall, branch, load_use, imem_stall.
REQ-007 RUN, no stall condition: all five loads SHALL be 1 and all flushes 0.
REQ-008 RUN, load_use only: load_pc=0, load_if_id=0, flush_id_ex=1, load_ex_mem=load_mem_wb=1 (one bubble, one cycle).
REQ-009 RUN, imem_stall only: load_pc=0, load_if_id=0, flush_id_ex=1, downstream loads 1.
REQ-010 RUN, br_taken with imem not stalled: flush_if_id, flush_id_ex and flush_ex_mem SHALL be 1; redirect=1 with redirect_target driven combinationally from br_target; load_pc=1; load_mem_wb=1; state stays RUN.
REQ-011 RUN, br_taken with imem_stall: the same three flushes SHALL assert; br_target SHALL be latched into redirect_target; load_pc=0; next state REDIR_PEND.
REQ-012 REDIR_PEND: load_pc, load_if_id=0 and flush_if_id=1 every cycle until imem_resp; in the imem_resp cycle redirect=1, load_pc=1, next state RUN; any new br_taken in REDIR_PEND SHALL be ignored, since the MEM stage holds only bubbles.
REQ-013 load_use concurrent with br_taken SHALL be discarded (branch wins).
REQ-014 stall_cycles SHALL increment by 1 on every cycle with reset=0 and load_pc=0, and SHALL saturate at all-ones without wrap.
REQ-015 redirect_target SHALL hold its value outside REQ-011 latching.

Reset
REQ-016 While reset=1: all load_* outputs 0, all flush_* outputs 1, redirect 0.
REQ-017 On the first clk edge with reset=1: state RUN, redirect_target 0, stall_cycles 0.
REQ-018 A reset asserted in REDIR_PEND SHALL abandon the pending redirect with no redirect pulse.

Structure
REQ-019 The shared pipeline package SHALL hold the FSM state enum, the register-index type (3 bits), and the 16-bit address type.
REQ-020 The saturating counter SHALL be a separate sub-module, sat_counter, parameterised on width.
REQ-021 All other logic SHALL be one combinational output block plus one clocked block for state, target and counter.

Verification
REQ-022 Reset 2 cycles, then idle with no requests -> all loads 1, flushes 0, stall_cycles 0.
REQ-023 ex_is_load=1, ex_dest=3, id_sr1=3, id_sr1_used=1 for 1 cycle -> load_pc=0, flush_id_ex=1 that cycle; stall_cycles=1 afterwards.
REQ-024 dmem_req=1 for 4 cycles with dmem_resp in the 4th, plus br_taken in cycle 2 -> no flush in cycles 1-3; stall_cycles=3.
REQ-025 imem_req=1, imem_resp=0, br_taken=1, br_target=0x3000, then imem_resp after 3 cycles -> REDIR_PEND entered; redirect=1 with target 0x3000 only in the resp cycle.
REQ-026 CNT_WIDTH=4 with 20 continuous imem_stall cycles -> stall_cycles stops at 0xF.
REQ-027 Reset asserted mid-REDIR_PEND -> state RUN, redirect never pulses, redirect_target=0.
